// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] CC_AND  = 4'b0000;
  localparam logic [3:0] CC_OR   = 4'b0001;
  localparam logic [3:0] CC_ADD  = 4'b0010;
  localparam logic [3:0] CC_XOR  = 4'b0011;
  localparam logic [3:0] CC_SLL  = 4'b0100;
  localparam logic [3:0] CC_SRL  = 4'b0101;
  localparam logic [3:0] CC_SUB  = 4'b0110;
  localparam logic [3:0] CC_SRA  = 4'b0111;
  localparam logic [3:0] CC_SLT  = 4'b1000;
  localparam logic [3:0] CC_SLTU = 4'b1001;
  localparam logic [3:0] CC_BEQ  = 4'b1010;
  localparam logic [3:0] CC_BNE  = 4'b1011;
  localparam logic [3:0] CC_BLT  = 4'b1100;
  localparam logic [3:0] CC_BGE  = 4'b1101;
  localparam logic [3:0] CC_BLTU = 4'b1110;
  localparam logic [3:0] CC_BGEU = 4'b1111;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] RW_RESULT = 2'b00;
  localparam logic [1:0] RW_PC4    = 2'b01;
  localparam logic [1:0] RW_IMM    = 2'b10;
  localparam logic [1:0] RW_PCIMM  = 2'b11;

  function automatic logic uses_imm(input logic [6:0] op);
    return (op == OP_IMM) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Maps the latched instruction fields to the ALU operation code.
module mc_alu_decode
  import mc_pkg::*;
#(
  parameter int ALU_CC_W = 4
) (
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  output logic [ALU_CC_W-1:0] alu_cc
);

  logic [3:0] cc;
  logic       unused_f7;

  // Only bit 5 of funct7 distinguishes RV32I operations.
  assign unused_f7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    cc = CC_AND;
    case (opcode)
      OP_R, OP_IMM: begin
        case (funct3)
          3'b000:  cc = (opcode == OP_R && funct7[5]) ? CC_SUB : CC_ADD;
          3'b001:  cc = CC_SLL;
          3'b010:  cc = CC_SLT;
          3'b011:  cc = CC_SLTU;
          3'b100:  cc = CC_XOR;
          3'b101:  cc = funct7[5] ? CC_SRA : CC_SRL;
          3'b110:  cc = CC_OR;
          default: cc = CC_AND;
        endcase
      end
      OP_LOAD, OP_STORE, OP_JALR: cc = CC_ADD;
      OP_BRANCH: begin
        case (funct3)
          3'b000:  cc = CC_BEQ;
          3'b001:  cc = CC_BNE;
          3'b100:  cc = CC_BLT;
          3'b101:  cc = CC_BGE;
          3'b110:  cc = CC_BLTU;
          3'b111:  cc = CC_BGEU;
          default: cc = CC_AND;
        endcase
      end
      default: cc = CC_AND;
    endcase
  end

  assign alu_cc = ALU_CC_W'(cc);

endmodule

// File: rtl/mc_controller.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer driving the RV32I datapath controls.
module mc_controller
  import mc_pkg::*;
#(
  parameter int ALU_CC_W = 4,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          Funct3,
  input  logic [6:0]          Funct7,
  input  logic                AluZero,
  input  logic                mem_ready,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic [1:0]          PCSel,
  output logic                RegWrite,
  output logic                MemtoReg,
  output logic                ALUsrc,
  output logic                MemWrite,
  output logic                MemRead,
  output logic [1:0]          RWSel,
  output logic [ALU_CC_W-1:0] ALU_CC,
  output logic                retire,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired_cnt
);

  state_e               state_q, state_d;
  logic [6:0]           op_q, op_d;
  logic [2:0]           f3_q, f3_d;
  logic [6:0]           f7_q, f7_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 illegal_q, illegal_d;
  logic [ALU_CC_W-1:0]  dec_cc;
  logic                 is_load, is_store, is_branch, retire_c;

  mc_alu_decode #(.ALU_CC_W(ALU_CC_W)) u_alu_decode (
    .opcode (op_q),
    .funct3 (f3_q),
    .funct7 (f7_q),
    .alu_cc (dec_cc)
  );

  assign is_load   = (op_q == OP_LOAD);
  assign is_store  = (op_q == OP_STORE);
  assign is_branch = (op_q == OP_BRANCH);
  assign retire_c  = (state_q == S_WB)
                   || (state_q == S_EXEC && is_branch)
                   || (state_q == S_MEM && is_store && mem_ready);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    f3_d      = f3_q;
    f7_d      = f7_q;
    illegal_d = illegal_q;
    cnt_d     = retire_c ? cnt_q + 1'b1 : cnt_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        f3_d = Funct3;
        f7_d = Funct7;
        case (opcode)
          OP_R, OP_IMM, OP_JALR, OP_LOAD, OP_STORE, OP_BRANCH: state_d = S_EXEC;
          OP_JAL, OP_LUI, OP_AUIPC:                            state_d = S_WB;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        if (is_branch)                state_d = S_FETCH;
        else if (is_load || is_store) state_d = S_MEM;
        else                          state_d = S_WB;
      end
      S_MEM:   if (mem_ready) state_d = is_store ? S_FETCH : S_WB;
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      f3_q      <= '0;
      f7_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      f3_q      <= f3_d;
      f7_q      <= f7_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Every output is forced low while reset is held so an aborted instruction cannot commit.
  always_comb begin
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCSel       = PC_PLUS4;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    ALUsrc      = 1'b0;
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    RWSel       = RW_RESULT;
    ALU_CC      = '0;
    retire      = 1'b0;
    illegal     = 1'b0;
    retired_cnt = '0;
    if (reset) begin
      illegal     = illegal_q;
      retired_cnt = cnt_q;
      case (state_q)
        S_FETCH: IRWrite = 1'b1;
        S_EXEC: begin
          ALU_CC = dec_cc;
          ALUsrc = uses_imm(op_q);
        end
        S_MEM: begin
          ALU_CC   = dec_cc;
          ALUsrc   = uses_imm(op_q);
          MemRead  = is_load;
          MemWrite = is_store;
        end
        S_WB: begin
          RegWrite = 1'b1;
          MemtoReg = is_load;
          case (op_q)
            OP_JAL, OP_JALR: RWSel = RW_PC4;
            OP_LUI:          RWSel = RW_IMM;
            OP_AUIPC:        RWSel = RW_PCIMM;
            default:         RWSel = RW_RESULT;
          endcase
        end
        default: ;
      endcase
      if (retire_c) begin
        retire  = 1'b1;
        PCWrite = 1'b1;
        if (op_q == OP_JAL || (is_branch && AluZero)) PCSel = PC_IMM;
        else if (op_q == OP_JALR)                     PCSel = PC_ALU;
      end
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: vector table, corner sequences, random instruction stream.
module tb_mc_controller;

  localparam int ALU_CC_W = 4;
  localparam int CNT_W    = 4;

  localparam logic [6:0] R = 7'b0110011, IMM = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4, PT = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] Funct3 = '0;
  logic [6:0] Funct7 = '0;
  logic AluZero = 1'b0, mem_ready = 1'b0;
  logic IRWrite, PCWrite, RegWrite, MemtoReg, ALUsrc, MemWrite, MemRead, retire, illegal;
  logic [1:0] PCSel, RWSel;
  logic [ALU_CC_W-1:0] ALU_CC;
  logic [CNT_W-1:0] retired_cnt;

  typedef struct packed {
    logic irw; logic pcw; logic [1:0] pcsel; logic regw; logic m2r; logic alusrc;
    logic memw; logic memr; logic [1:0] rwsel; logic [3:0] cc; logic ret; logic ill;
  } outs_t;

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic z; int waits;
    int cyc; logic [3:0] cc; logic [1:0] rw; logic [1:0] pcsel;
  } vec_t;

  outs_t act_o;
  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] mcnt = '0;

  always #5 clk = ~clk;

  mc_controller #(.ALU_CC_W(ALU_CC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .Funct3(Funct3), .Funct7(Funct7),
    .AluZero(AluZero), .mem_ready(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSel(PCSel), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUsrc(ALUsrc),
    .MemWrite(MemWrite), .MemRead(MemRead), .RWSel(RWSel), .ALU_CC(ALU_CC),
    .retire(retire), .illegal(illegal), .retired_cnt(retired_cnt)
  );

  assign act_o = {IRWrite, PCWrite, PCSel, RegWrite, MemtoReg, ALUsrc, MemWrite, MemRead,
                  RWSel, ALU_CC, retire, illegal};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] m_cc(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    logic [3:0] base [8];
    int br [8];
    base = '{4'd2, 4'd4, 4'd8, 4'd9, 4'd3, 4'd5, 4'd1, 4'd0};
    br   = '{0, 1, 0, 0, 2, 3, 4, 5};
    if (op == R || op == IMM) begin
      if (f7[5] && f3 == 3'd5) return 4'd7;
      if (f7[5] && f3 == 3'd0 && op == R) return 4'd6;
      return base[f3];
    end
    if (op == LD || op == ST || op == JALR) return 4'd2;
    if (op == BR) return 4'(10 + br[f3]);
    return 4'd0;
  endfunction

  function automatic outs_t exp_out(input int ph, input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic z, input bit last);
    outs_t e = '0;
    case (ph)
      PF: e.irw = 1'b1;
      PE: begin
        e.cc = m_cc(op, f3, f7);
        e.alusrc = (op == IMM || op == LD || op == ST || op == JALR);
      end
      PM: begin
        e.cc = m_cc(op, f3, f7);
        e.alusrc = 1'b1;
        e.memr = (op == LD);
        e.memw = (op == ST);
      end
      PW: begin
        e.regw = 1'b1;
        e.m2r = (op == LD);
        e.rwsel = (op == JAL || op == JALR) ? 2'd1 : (op == LUI) ? 2'd2 : (op == AUIPC) ? 2'd3 : 2'd0;
      end
      PT: e.ill = 1'b1;
      default: ;
    endcase
    if (last) begin
      e.ret = 1'b1;
      e.pcw = 1'b1;
      e.pcsel = (op == JAL || (op == BR && z)) ? 2'd1 : (op == JALR) ? 2'd2 : 2'd0;
    end
    return e;
  endfunction

  task automatic reset_cycle(input string nm);
    @(posedge clk); #1;
    reset = 1'b0;
    opcode = 7'($urandom); Funct3 = 3'($urandom); Funct7 = 7'($urandom);
    AluZero = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check({nm, "_rst_out"}, 32'(act_o), 32'd0);
    check({nm, "_rst_cnt"}, 32'(retired_cnt), 32'd0);
    mcnt = '0;
  endtask

  // Runs one instruction cycle by cycle; abort_at >= 0 replaces that cycle with a reset cycle.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input int waits, input int abort_at, input string nm,
                           output int obs_cyc, output logic [3:0] obs_cc,
                           output logic [1:0] obs_rw, output logic [1:0] obs_pcsel);
    int ph[$];
    int mseen = 0;
    bit last;
    outs_t e;
    obs_cyc = 0; obs_cc = '0; obs_rw = '0; obs_pcsel = '0;
    ph = {PF, PD};
    if (op == R || op == IMM || op == JALR) ph = {ph, PE, PW};
    else if (op == LD || op == ST) begin
      ph.push_back(PE);
      for (int k = 0; k <= waits; k++) ph.push_back(PM);
      if (op == LD) ph.push_back(PW);
    end
    else if (op == BR) ph.push_back(PE);
    else ph.push_back(PW);
    for (int i = 0; i < ph.size(); i++) begin
      if (i == abort_at) begin
        reset_cycle(nm);
        return;
      end
      @(posedge clk); #1;
      reset = 1'b1;
      if (i <= 1) begin
        opcode = op; Funct3 = f3; Funct7 = f7;
      end else begin
        opcode = 7'($urandom); Funct3 = 3'($urandom); Funct7 = 7'($urandom);
      end
      AluZero = (op == BR) ? z : 1'($urandom);
      if (ph[i] == PM) begin
        mem_ready = (mseen >= waits);
        mseen++;
      end else mem_ready = 1'($urandom);
      last = (i == ph.size() - 1);
      e = exp_out(ph[i], op, f3, f7, z, last);
      @(negedge clk);
      check($sformatf("%s_c%0d_out", nm, i), 32'(act_o), 32'(e));
      check($sformatf("%s_c%0d_cnt", nm, i), 32'(retired_cnt), 32'(mcnt));
      if (i == 2) obs_cc = ALU_CC;
      if (retire && obs_cyc == 0) begin
        obs_cyc = i + 1; obs_rw = RWSel; obs_pcsel = PCSel;
      end
      if (last) mcnt = mcnt + 1'b1;
    end
  endtask

  task automatic trap_seq(input logic [6:0] op, input int hold, input string nm);
    outs_t e;
    for (int i = 0; i < 2 + hold; i++) begin
      @(posedge clk); #1;
      reset = 1'b1;
      opcode = (i <= 1) ? op : 7'($urandom);
      Funct3 = 3'($urandom); Funct7 = 7'($urandom);
      AluZero = 1'($urandom); mem_ready = 1'($urandom);
      e = exp_out((i == 0) ? PF : (i == 1) ? PD : PT, op, 3'd0, 7'd0, 1'b0, 1'b0);
      @(negedge clk);
      check($sformatf("%s_c%0d_out", nm, i), 32'(act_o), 32'(e));
      check($sformatf("%s_c%0d_cnt", nm, i), 32'(retired_cnt), 32'(mcnt));
    end
    reset_cycle(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [16];
    int oc;
    logic [3:0] ocv;
    logic [1:0] orw, ops;
    logic [6:0] legal [9];
    logic [2:0] brf3 [6];

    tbl[0]  = '{R,   3'b000, 7'h00, 1'b0, 0, 4, 4'b0010, 2'b00, 2'b00};
    tbl[1]  = '{R,   3'b000, 7'h20, 1'b0, 0, 4, 4'b0110, 2'b00, 2'b00};
    tbl[2]  = '{R,   3'b101, 7'h20, 1'b0, 0, 4, 4'b0111, 2'b00, 2'b00};
    tbl[3]  = '{IMM, 3'b101, 7'h20, 1'b0, 0, 4, 4'b0111, 2'b00, 2'b00};
    tbl[4]  = '{IMM, 3'b000, 7'h20, 1'b0, 0, 4, 4'b0010, 2'b00, 2'b00};
    tbl[5]  = '{R,   3'b011, 7'h00, 1'b0, 0, 4, 4'b1001, 2'b00, 2'b00};
    tbl[6]  = '{LD,  3'b010, 7'h00, 1'b0, 3, 8, 4'b0010, 2'b00, 2'b00};
    tbl[7]  = '{ST,  3'b010, 7'h00, 1'b0, 0, 4, 4'b0010, 2'b00, 2'b00};
    tbl[8]  = '{BR,  3'b000, 7'h00, 1'b1, 0, 3, 4'b1010, 2'b00, 2'b01};
    tbl[9]  = '{BR,  3'b000, 7'h00, 1'b0, 0, 3, 4'b1010, 2'b00, 2'b00};
    tbl[10] = '{BR,  3'b111, 7'h00, 1'b1, 0, 3, 4'b1111, 2'b00, 2'b01};
    tbl[11] = '{JAL, 3'b000, 7'h00, 1'b0, 0, 3, 4'b0000, 2'b01, 2'b01};
    tbl[12] = '{LUI, 3'b000, 7'h00, 1'b0, 0, 3, 4'b0000, 2'b10, 2'b00};
    tbl[13] = '{AUIPC, 3'b000, 7'h00, 1'b0, 0, 3, 4'b0000, 2'b11, 2'b00};
    tbl[14] = '{JALR, 3'b000, 7'h00, 1'b0, 0, 4, 4'b0010, 2'b01, 2'b10};
    tbl[15] = '{IMM, 3'b001, 7'h00, 1'b0, 0, 4, 4'b0100, 2'b00, 2'b00};
    legal = '{R, IMM, LD, ST, BR, JAL, JALR, LUI, AUIPC};
    brf3  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    reset_cycle("init0");
    reset_cycle("init1");

    for (int v = 0; v < 16; v++) begin
      run_instr(tbl[v].op, tbl[v].f3, tbl[v].f7, tbl[v].z, tbl[v].waits, -1,
                $sformatf("vec%0d", v), oc, ocv, orw, ops);
      check($sformatf("vec%0d_cycles", v), 32'(oc), 32'(tbl[v].cyc));
      check($sformatf("vec%0d_cc", v), 32'(ocv), 32'(tbl[v].cc));
      check($sformatf("vec%0d_rwsel", v), 32'(orw), 32'(tbl[v].rw));
      check($sformatf("vec%0d_pcsel", v), 32'(ops), 32'(tbl[v].pcsel));
    end

    // JAL, LUI, AUIPC from a fresh reset: counter reaches 3 at the next FETCH.
    reset_cycle("seq3");
    run_instr(JAL,   3'd0, 7'd0, 1'b0, 0, -1, "seq_jal",   oc, ocv, orw, ops);
    run_instr(LUI,   3'd0, 7'd0, 1'b0, 0, -1, "seq_lui",   oc, ocv, orw, ops);
    run_instr(AUIPC, 3'd0, 7'd0, 1'b0, 0, -1, "seq_auipc", oc, ocv, orw, ops);
    check("seq3_model_cnt", 32'(mcnt), 32'd3);
    run_instr(R, 3'd0, 7'd0, 1'b0, 0, -1, "seq_after", oc, ocv, orw, ops);

    trap_seq(7'b1111111, 10, "trap");
    run_instr(R, 3'd0, 7'd0, 1'b0, 0, -1, "post_trap", oc, ocv, orw, ops);

    // Reset lands in the second MEM wait cycle of a store.
    run_instr(ST, 3'd2, 7'd0, 1'b0, 5, 4, "st_abort", oc, ocv, orw, ops);
    check("st_abort_no_retire", 32'(oc), 32'd0);
    run_instr(R, 3'd0, 7'd0, 1'b0, 0, -1, "post_abort", oc, ocv, orw, ops);

    for (int n = 0; n < 200; n++) begin
      logic [6:0] op;
      logic [2:0] f3;
      int w;
      if ($urandom_range(0, 39) == 0) begin
        trap_seq({5'($urandom), 2'b00}, $urandom_range(1, 4), $sformatf("rtrap%0d", n));
      end else begin
        op = legal[$urandom_range(0, 8)];
        f3 = (op == BR) ? brf3[$urandom_range(0, 5)] : 3'($urandom);
        w = $urandom_range(0, 3);
        run_instr(op, f3, 7'($urandom), 1'($urandom), w,
                  ((op == LD || op == ST) && $urandom_range(0, 19) == 0) ? 3 + $urandom_range(0, w) : -1,
                  $sformatf("rnd%0d", n), oc, ocv, orw, ops);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle sequencer for the RV32I datapath. It replaces the single-cycle control path with a FETCH/DECODE/EXEC/MEM/WB state machine. Each instruction is spread over 3–5 cycles, and PC and register-file writes are gated so each happens once per instruction. It sits beside the datapath: it consumes opcode, Funct3, Funct7 and the ALU Zero flag, and drives every datapath control input plus PC and IR enables.

## Interface
Parameters:
- ALU_CC_W, 4, ALU control code width
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  input  1  clock
- reset  input  1  reset; synchronous, active-low
- opcode  input  7  Instr[6:0] from datapath
- Funct3  input  3  Instr[14:12]
- Funct7  input  7  Instr[31:25]
- AluZero  input  1  ALU condition flag (1 = branch condition true / result zero)
- mem_ready  input  1  data memory completion handshake
- IRWrite  output  1  instruction register load enable
- PCWrite  output  1  PC register load enable
- PCSel  output  2  next PC: 00 PC+4, 01 PC+Imm, 10 ALUResult
- RegWrite, MemtoReg, ALUsrc, MemWrite, MemRead  output  1 each  datapath controls
- RWSel  output  2  writeback mux: 00 Result, 01 PC+4, 10 ExtImm, 11 PC+Imm
- ALU_CC  output  ALU_CC_W  ALU operation
- retire  output  1  one-cycle pulse in each instruction's final cycle
- illegal  output  1  sticky illegal-opcode flag
- retired_cnt  output  CNT_W  count of retired instructions

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: IRWrite=1; always go to DECODE.
- DECODE: latch opcode/Funct3/Funct7 into internal registers. All later decoding uses the latched copies.
- Paths by opcode:
  - R 0110011 / I-ALU 0010011 / JALR 1100111: DECODE→EXEC→WB.
  - LOAD 0000011: DECODE→EXEC→MEM→WB.
  - STORE 0100011: DECODE→EXEC→MEM.
  - BRANCH 1100011: DECODE→EXEC.
  - JAL 1101111 / LUI 0110111 / AUIPC 0010111: DECODE→WB.
  - Any other opcode: DECODE→TRAP.
- ALU_CC is valid in EXEC and MEM and is 0 elsewhere. Codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001.
  - R-type: ADD vs SUB and SRL vs SRA are selected by Funct7[5].
  - I-ALU: only SRLI/SRAI use Funct7[5].
  - LOAD, STORE, JALR use ADD with ALUsrc=1.
  - BRANCH codes by Funct3: BEQ 1010, BNE 1011, BLT 1100, BGE 1101, BLTU 1110, BGEU 1111.
- ALUsrc=1 in EXEC/MEM for I-ALU, LOAD, STORE, JALR.
- MEM: MemRead (load) or MemWrite (store) is held asserted while mem_ready=0. The state advances on the first cycle with mem_ready=1.
- WB: RegWrite=1.
  - RWSel: 00 for R, I-ALU, LOAD; 01 for JAL, JALR; 10 for LUI; 11 for AUIPC.
  - MemtoReg=1 only for LOAD.
- Retire cycle is WB, STORE's MEM (when mem_ready=1), or BRANCH's EXEC. In that cycle:
  - retire=1, PCWrite=1, retired_cnt increments by 1, next state FETCH.
  - PCSel=01 for JAL, or for BRANCH when AluZero=1.
  - PCSel=10 for JALR.
  - PCSel=00 otherwise.
- retired_cnt wraps modulo 2^CNT_W.
- TRAP: illegal=1. All enables and writes are 0. Only reset leaves TRAP.
- Outputs are combinational decodes of the state register and the latched fields (Moore). None depend combinationally on opcode, except the state transition in DECODE.

## Timing
- Reset (reset=0 at a clk edge): state=FETCH, latched fields=0, retired_cnt=0, illegal=0.
  - During reset, all outputs are 0, including IRWrite.
  - First FETCH (IRWrite=1) occurs in the first cycle after reset is released.
- Reset asserted mid-instruction (including during a MEM wait) aborts the instruction: no PCWrite, RegWrite or retire is issued in that cycle.
- Latency, with zero memory wait:
  - BRANCH, JAL, LUI, AUIPC: 3 cycles.
  - R, I-ALU, JALR, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each mem_ready=0 cycle in MEM adds one.
- mem_ready is ignored outside MEM.
- At most one PCWrite, RegWrite and retire per instruction.

## Structure
- Package mc_pkg holds:
  - the state enum
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - ALU_CC localparams
  - PCSel and RWSel encodings
- One sub-module, mc_alu_decode: combinational map from (latched opcode, Funct3, Funct7) to ALU_CC.
- The FSM and counter live in mc_controller.

## Test plan
- reset=0 for 2 cycles, then 1, with ADD opcode 0110011 / Funct3 000 / Funct7 0000000 → IRWrite in cycle 1; ALU_CC=0010 in EXEC; RegWrite, RWSel=00 and PCWrite, PCSel=00 in WB; retired_cnt=1 after 4 cycles.
- LOAD (0000011) with mem_ready low for 3 cycles → MemRead held for 4 MEM cycles; MemtoReg=1 in WB; total 8 cycles; single retire pulse.
- BEQ (Funct3 000): AluZero=1 → ALU_CC=1010, PCSel=01, PCWrite in cycle 3. With AluZero=0 → PCSel=00; RegWrite never asserted.
- JAL, then LUI, then AUIPC → WB RWSel=01/10/11 respectively; JAL's PCSel=01; each takes 3 cycles; retired_cnt=3.
- Opcode 1111111 → TRAP on cycle 3; illegal=1 and all enables 0 for 10 cycles. Pulsing reset low clears illegal and restarts at FETCH.
- Reset low during STORE's MEM wait → no MemWrite, PCWrite or retire in the reset cycle; retired_cnt=0.
